// File: rtl/fsm_q6_pkg.sv
// Shared definitions for the six-state one-hot A..F detector.
// State bit indices, state encodings and a one-hot legality helper.
package fsm_q6_pkg;

  localparam int NUM_STATES = 6;

  localparam int S_A = 1;
  localparam int S_B = 2;
  localparam int S_C = 3;
  localparam int S_D = 4;
  localparam int S_E = 5;
  localparam int S_F = 6;

  typedef enum logic [NUM_STATES-1:0] {
    ST_A = 6'b000001,
    ST_B = 6'b000010,
    ST_C = 6'b000100,
    ST_D = 6'b001000,
    ST_E = 6'b010000,
    ST_F = 6'b100000
  } state_e;

  function automatic logic onehot_ok(
    input logic [NUM_STATES-1:0] v
  );
    return ($countones(v) == 1);
  endfunction

endpackage

// File: rtl/fsm_q6_next_state.sv
// Combinational next-state stage of the A..F one-hot detector.
// Bit i-1 of y/y_n is state i (A=bit 0, F=bit 5).
module fsm_q6_next_state
  import fsm_q6_pkg::*;
(
  input  logic [5:0] y,
  input  logic       w,
  output logic [5:0] y_n
);

  logic a, b, c, d, e, f;

  assign a = y[S_A-1];
  assign b = y[S_B-1];
  assign c = y[S_C-1];
  assign d = y[S_D-1];
  assign e = y[S_E-1];
  assign f = y[S_F-1];

  // Per-bit next-state equations
  always_comb begin
    y_n          = '0;
    y_n[S_A-1]   = (a | d) & w;
    y_n[S_B-1]   = a & ~w;
    y_n[S_C-1]   = (b | f) & ~w;
    y_n[S_D-1]   = (b | c | e | f) & w;
    y_n[S_E-1]   = (c | e) & ~w;
    y_n[S_F-1]   = d & ~w;
  end

endmodule

// File: rtl/fsm_q6_onehot_core.sv
// Registered one-hot A..F detector with Moore z and saturating count.
// Define FSM_Q6_ONEHOT_CHECK_EN for illegal-vector detect and recovery.
module fsm_q6_onehot_core
  import fsm_q6_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int RESET_STATE = 1
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             w_valid,
  input  logic             w,
  input  logic             clr_cnt,
  output logic [5:0]       y,
  output logic             z,
  output logic [CNT_W-1:0] trans_cnt,
  output logic             onehot_err
);

  localparam logic [5:0] RST_VEC = 6'b000001 << (RESET_STATE - 1);

  logic [5:0]       y_q, y_d, y_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bad;

  fsm_q6_next_state u_ns (
    .y   (y_q),
    .w   (w),
    .y_n (y_nxt)
  );

`ifdef FSM_Q6_ONEHOT_CHECK_EN
  logic err_q, err_d;

  assign bad = ~onehot_ok(y_q);
`else
  assign bad = 1'b0;
`endif

  // Next state, counter and sticky error; recovery overrides w_valid
  always_comb begin
    y_d   = y_q;
    cnt_d = cnt_q;
    if (w_valid && !bad) begin
      y_d = y_nxt;
      if (cnt_q != {CNT_W{1'b1}})
        cnt_d = cnt_q + 1'b1;
    end
    if (bad)
      y_d = RST_VEC;
    if (clr_cnt)
      cnt_d = '0;
  end

`ifdef FSM_Q6_ONEHOT_CHECK_EN
  // Error flag latches on any illegal vector until reset
  always_comb begin
    err_d = err_q | bad;
  end

  // Sticky error register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)
      err_q <= 1'b0;
    else
      err_q <= err_d;
  end

  assign onehot_err = err_q | bad;
`else
  assign onehot_err = 1'b0;
`endif

  // State and counter registers
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      y_q   <= RST_VEC;
      cnt_q <= '0;
    end else begin
      y_q   <= y_d;
      cnt_q <= cnt_d;
    end
  end

  assign y         = y_q;
  assign z         = y_q[S_E-1] | y_q[S_F-1];
  assign trans_cnt = cnt_q;

endmodule

// File: tb/tb_fsm_q6_onehot_core.sv
// Directed bench for fsm_q6_onehot_core (default and CNT_W=2 instances).
// Build with FSM_Q6_ONEHOT_CHECK_EN to exercise illegal-vector recovery.
module tb_fsm_q6_onehot_core;
  import fsm_q6_pkg::*;

  logic       clk;
  logic       aresetn;
  logic       w_valid;
  logic       w;
  logic       clr_cnt;
  logic [5:0] y, y2;
  logic       z, z2;
  logic [7:0] cnt;
  logic [1:0] cnt2;
  logic       err, err2;

  int checks = 0;
  int errors = 0;

  fsm_q6_onehot_core dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .w_valid    (w_valid),
    .w          (w),
    .clr_cnt    (clr_cnt),
    .y          (y),
    .z          (z),
    .trans_cnt  (cnt),
    .onehot_err (err)
  );

  fsm_q6_onehot_core #(.CNT_W(2)) dut2 (
    .clk        (clk),
    .aresetn    (aresetn),
    .w_valid    (w_valid),
    .w          (w),
    .clr_cnt    (clr_cnt),
    .y          (y2),
    .z          (z2),
    .trans_cnt  (cnt2),
    .onehot_err (err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic wi, input logic clr);
    w_valid = v;
    w       = wi;
    clr_cnt = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic st(input string tag, input logic [5:0] ey,
                    input logic ez, input logic [7:0] ec);
    chk({tag, "_y"}, {26'd0, y}, {26'd0, ey});
    chk({tag, "_z"}, {31'd0, z}, {31'd0, ez});
    chk({tag, "_cnt"}, {24'd0, cnt}, {24'd0, ec});
  endtask

  initial begin
    aresetn = 1'b0;
    w_valid = 1'b0;
    w       = 1'b0;
    clr_cnt = 1'b0;
    #12;
    st("rst", ST_A, 1'b0, 8'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_cnt2", {30'd0, cnt2}, 32'd0);
    @(negedge clk);
    aresetn = 1'b1;

    step(1'b1, 1'b0, 1'b0);
    st("s1", ST_B, 1'b0, 8'd1);
    chk("s1_cnt2", {30'd0, cnt2}, 32'd1);
    step(1'b1, 1'b0, 1'b0);
    st("s2", ST_C, 1'b0, 8'd2);
    chk("s2_cnt2", {30'd0, cnt2}, 32'd2);
    step(1'b1, 1'b0, 1'b0);
    st("s3", ST_E, 1'b1, 8'd3);
    chk("s3_cnt2", {30'd0, cnt2}, 32'd3);
    step(1'b1, 1'b0, 1'b0);
    st("s4", ST_E, 1'b1, 8'd4);
    chk("s4_cnt2_sat", {30'd0, cnt2}, 32'd3);
    step(1'b1, 1'b1, 1'b0);
    st("s5", ST_D, 1'b0, 8'd5);
    chk("s5_cnt2_sat", {30'd0, cnt2}, 32'd3);
    step(1'b1, 1'b0, 1'b1);
    st("s6_clr", ST_F, 1'b1, 8'd0);
    chk("s6_cnt2_clr", {30'd0, cnt2}, 32'd0);
    step(1'b1, 1'b0, 1'b0);
    st("s7", ST_C, 1'b0, 8'd1);

    for (int i = 0; i < 5; i++) begin
      step(1'b0, i[0], 1'b0);
      st("hold", ST_C, 1'b0, 8'd1);
    end

    step(1'b1, 1'b1, 1'b0);
    st("s8", ST_D, 1'b0, 8'd2);
    step(1'b1, 1'b0, 1'b0);
    st("s9", ST_F, 1'b1, 8'd3);

    #2;
    aresetn = 1'b0;
    #1;
    st("async_rst", ST_A, 1'b0, 8'd0);
    chk("async_cnt2", {30'd0, cnt2}, 32'd0);
    @(negedge clk);
    aresetn = 1'b1;

    w_valid = 1'b0;
    force dut.y_q = 6'b000110;
    #1;
    release dut.y_q;
`ifdef FSM_Q6_ONEHOT_CHECK_EN
    chk("err_detect", {31'd0, err}, 32'd1);
    step(1'b1, 1'b0, 1'b0);
    st("recover", ST_A, 1'b0, 8'd0);
    chk("err_sticky", {31'd0, err}, 32'd1);
    step(1'b1, 1'b0, 1'b0);
    st("post_rec", ST_B, 1'b0, 8'd1);
    chk("err_sticky2", {31'd0, err}, 32'd1);
`else
    chk("err_off", {31'd0, err}, 32'd0);
    step(1'b1, 1'b0, 1'b0);
    st("illegal_prop", 6'b010100, 1'b1, 8'd1);
    chk("err_off2", {31'd0, err}, 32'd0);
`endif
    aresetn = 1'b0;
    #1;
    chk("err_reset", {31'd0, err}, 32'd0);
    chk("y_reset", {26'd0, y}, {26'd0, ST_A});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_q6_onehot_core.md
Name: fsm_q6_onehot_core

Overview:
- Registered one-hot state machine for the six-state A..F sequence detector: states A..F are held in flops y[6:1]; A=y[1], F=y[6].
- Consumes a qualified input bit w and feeds the state vector back into the combinational next-state stage (Y1..Y6 equations).
- Produces the Moore output z, a transition counter and a sticky one-hot error flag.
- Sits between the input sampler and the downstream pattern-report logic.

Parameters:
- CNT_W, 8, width of the saturating transition counter.
- RESET_STATE, 1, index (1..6) of the one-hot bit set at reset and on recovery; legal values 1..6 only.

Ports:
- clk  in  1  rising-edge clock.
- aresetn  in  1  asynchronous active-low reset.
- w_valid  in  1  w is valid this cycle; state advances only when high.
- w  in  1  FSM input bit.
- clr_cnt  in  1  synchronous clear of trans_cnt.
- y  out  6  current one-hot state, bit i-1 = state (A..F).
- z  out  1  Moore output, 1 in states E or F.
- trans_cnt  out  CNT_W  count of accepted w_valid cycles, saturating.
- onehot_err  out  1  sticky: illegal state vector detected.

Behaviour:
- Reset (aresetn low, asynchronous assert, synchronous deassert at the reset synchroniser upstream): y = 1<<(RESET_STATE-1) (default 6'b000001, state A); z = 0; trans_cnt = 0; onehot_err = 0.
- Transition table, applied only on a clk edge with w_valid=1:
  - A: w0->B, w1->A
  - B: w0->C, w1->D
  - C: w0->E, w1->D
  - D: w0->F, w1->A
  - E: w0->E, w1->D
  - F: w0->C, w1->D
- Next-state equations per bit:
  - Y1 = (y1|y4)&w
  - Y2 = y1&~w
  - Y3 = (y2|y6)&~w
  - Y4 = (y2|y3|y5|y6)&w
  - Y5 = (y3|y5)&~w
  - Y6 = y4&~w
- w_valid=0: y holds; w is ignored.
- Latency: y updates one cycle after the accepted edge. z = y[5]|y[6] is combinational from the registered y, so it is glitch-free relative to the flops.
- trans_cnt:
  - Increments by 1 on each accepted cycle (w_valid=1).
  - Saturates at 2^CNT_W-1; no wrap.
  - clr_cnt=1 loads 0 and has priority over an increment in the same cycle.
- Reset mid-operation: all outputs return to reset values immediately; any in-flight w is discarded.
- Illegal y (zero bits or more than one bit set) can only arise from an upset; handling is defined under Optional Feature.

Optional Feature:
- Macro: FSM_Q6_ONEHOT_CHECK_EN.
- Defined:
  - Each cycle, y is checked for popcount != 1.
  - On detection: onehot_err is set (sticky until reset), and at the next edge y is forced to RESET_STATE regardless of w_valid.
  - trans_cnt does not increment in a recovery cycle.
- Undefined:
  - onehot_err is tied to 0.
  - y follows the equations unconditionally (an illegal vector propagates per the equations).

Decomposition:
- Shared package fsm_q6_pkg:
  - Bit-index constants S_A=1 .. S_F=6.
  - NUM_STATES=6.
  - Function onehot_ok(y) returning popcount==1.
- One sub-module: fsm_q6_next_state (purely combinational, input y[6:1] and w, output Y[6:1]). The core instantiates it and registers Y when w_valid=1.

Test Plan:
- Reset, then w_valid=1 with w sequence 0,0,0 -> y = B(000010), C(000100), E(010000); z=1 on the third; trans_cnt=3.
- From E: w=0 -> y stays E, z=1; then w=1 -> D(001000), z=0; then w=0 -> F(100000), z=1; then w=0 -> C.
- w_valid=0 for 5 cycles with w toggling -> y, z, trans_cnt unchanged.
- CNT_W=2: apply 5 accepted cycles -> trans_cnt 1,2,3,3,3; then assert clr_cnt together with w_valid=1 -> trans_cnt=0.
- Assert aresetn=0 asynchronously mid-cycle while in F -> y=000001, z=0, trans_cnt=0 before the next clk edge.
- With FSM_Q6_ONEHOT_CHECK_EN: force y=6'b000110 -> onehot_err=1; next edge y=000001; onehot_err stays 1 until reset. Without the macro -> onehot_err stays 0.
